// File: rtl/sram_req_arbiter_pkg.sv
// Shared CPU bus header: arbiter state encodings, grant sides and transfer size codes.
// Used by sram_req_arbiter and sram_arb_pick2 (round-robin build: SRAM_ARB_RR_EN).
package sram_req_arbiter_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_pick2.sv
// Two-way winner selection for the SRAM port arbiter plus its fairness state.
// Default: data priority with a starvation counter; SRAM_ARB_RR_EN selects round-robin.
module sram_arb_pick2 #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    input  logic pick_en,
    output logic winner
);
    import sram_req_arbiter_pkg::*;

`ifdef SRAM_ARB_RR_EN
    logic last_gnt;

    always_comb begin
        winner = GNT_INST;
        if (data_req && !inst_req) begin
            winner = GNT_DATA;
        end else if (data_req && inst_req) begin
            winner = ~last_gnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= GNT_INST;
        end else if (pick_en) begin
            last_gnt <= winner;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Inst only overrides data once it has watched LIMIT data grants go by.
    always_comb begin
        winner = GNT_INST;
        if (data_req && !(inst_req && starve_cnt == LIMIT)) begin
            winner = GNT_DATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 4'd0;
        end else if (!inst_req) begin
            starve_cnt <= 4'd0;
        end else if (pick_en) begin
            if (winner == GNT_INST) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like master port between the IF and EXE/MEM requesters, one transaction in flight.
// Arbitration policy comes from sram_arb_pick2; define SRAM_ARB_RR_EN for round-robin.
module sram_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    import sram_req_arbiter_pkg::*;

    arb_state_t state, state_next;
    logic       gnt, gnt_next;
    logic       pick_en;
    logic       winner;
    logic       gnt_req;
    logic       any_req;

    assign any_req = inst_req | data_req;
    assign gnt_req = (gnt == GNT_DATA) ? data_req : inst_req;

    sram_arb_pick2 #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk     (clk),
        .resetn  (resetn),
        .inst_req(inst_req),
        .data_req(data_req),
        .pick_en (pick_en),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            gnt   <= GNT_INST;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
        end
    end

    // A response that finds another request waiting re-arbitrates straight into REQ.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        pick_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    pick_en    = 1'b1;
                    gnt_next   = winner;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!gnt_req) begin
                    state_next = ST_IDLE;
                end else if (m_addr_ok) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_data_ok) begin
                    if (any_req) begin
                        pick_en    = 1'b1;
                        gnt_next   = winner;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_wr    = 1'b0;
        m_size  = SIZE_WORD;
        m_wstrb = 4'b0000;
        m_addr  = inst_addr;
        m_wdata = 32'd0;
        if (gnt == GNT_DATA) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end
    end

    assign m_req        = (state == ST_REQ) && gnt_req;
    assign inst_addr_ok = m_req && m_addr_ok && (gnt == GNT_INST);
    assign data_addr_ok = m_req && m_addr_ok && (gnt == GNT_DATA);
    assign inst_data_ok = (state == ST_RESP) && m_data_ok && (gnt == GNT_INST);
    assign data_data_ok = (state == ST_RESP) && m_data_ok && (gnt == GNT_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed protocol scenarios plus randomized traffic against a
// transaction-level model of who owns the port; honours SRAM_ARB_RR_EN like the design.
module tb_sram_req_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    sram_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: which side currently owns the port, whether the slave has taken its
    // request, and the fairness history (data-grant streak or last winner).
    int  mdl_owner = -1;
    bit  mdl_acc = 1'b0;
    int  mdl_streak = 0;
    int  mdl_last = 0;
    bit  log_en = 1'b0;
    int  grant_log[$];

    function automatic int mdl_choose(input bit i, input bit d);
        if (i && !d) return 0;
        if (d && !i) return 1;
`ifdef SRAM_ARB_RR_EN
        return (mdl_last == 1) ? 0 : 1;
`else
        return (mdl_streak == LIMIT) ? 0 : 1;
`endif
    endfunction

    task automatic mdl_grant(input int w);
        mdl_owner = w;
        mdl_last  = w;
        if (w == 0) mdl_streak = 0;
        else if (inst_req) mdl_streak = (mdl_streak >= 15) ? 15 : mdl_streak + 1;
    endtask

    always @(negedge clk) begin
        bit own_req, exp_mreq;
        if (!resetn) begin
            mdl_owner = -1;
            mdl_acc = 1'b0;
            mdl_streak = 0;
            mdl_last = 0;
            check("rst m_req", 32'(m_req), 32'd0);
            check("rst addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            check("rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        end else begin
            own_req  = (mdl_owner == 0) ? inst_req : (mdl_owner == 1) ? data_req : 1'b0;
            exp_mreq = (mdl_owner >= 0) && !mdl_acc && own_req;
            check("m_req", 32'(m_req), 32'(exp_mreq));
            if (exp_mreq && mdl_owner == 0) begin
                check("inst m_addr", m_addr, inst_addr);
                check("inst m_ctl", 32'({m_wr, m_size, m_wstrb}), 32'({1'b0, 2'd2, 4'd0}));
            end
            if (exp_mreq && mdl_owner == 1) begin
                check("data m_addr", m_addr, data_addr);
                check("data m_wdata", m_wdata, data_wdata);
                check("data m_ctl", 32'({m_wr, m_size, m_wstrb}),
                      32'({data_wr, data_size, data_wstrb}));
            end
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_mreq && mdl_owner == 0 && m_addr_ok));
            check("data_addr_ok", 32'(data_addr_ok), 32'(exp_mreq && mdl_owner == 1 && m_addr_ok));
            check("inst_data_ok", 32'(inst_data_ok), 32'(mdl_acc && mdl_owner == 0 && m_data_ok));
            check("data_data_ok", 32'(data_data_ok), 32'(mdl_acc && mdl_owner == 1 && m_data_ok));
            if (mdl_acc && m_data_ok) begin
                check("rdata", (mdl_owner == 0) ? inst_rdata : data_rdata, m_rdata);
            end
            if (log_en && inst_addr_ok) grant_log.push_back(0);
            if (log_en && data_addr_ok) grant_log.push_back(1);

            if (!inst_req) mdl_streak = 0;
            if (mdl_owner < 0) begin
                if (inst_req || data_req) mdl_grant(mdl_choose(inst_req, data_req));
            end else if (!mdl_acc) begin
                if (!own_req) mdl_owner = -1;
                else if (m_addr_ok) mdl_acc = 1'b1;
            end else if (m_data_ok) begin
                mdl_acc = 1'b0;
                if (inst_req || data_req) mdl_grant(mdl_choose(inst_req, data_req));
                else mdl_owner = -1;
            end
        end
    end

    // Environment: two requesters honouring hold-until-addr_ok and a slave with random latency.
    bit keep_inst = 0, keep_data = 0;
    int p_inst = 0, p_data = 0, p_aok = 0, p_spur = 0, p_drop = 0, max_lat = 0;
    bit sl_busy = 0;
    int sl_lat = 0;
    bit s_iack, s_dack, s_macc;

    function automatic bit chance(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic new_data_fields();
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    task automatic env_tick();
        if (inst_req && s_iack) begin
            inst_req  = keep_inst || chance(p_inst);
            inst_addr = $urandom;
        end else if (inst_req) begin
            if (chance(p_drop)) inst_req = 1'b0;
        end else if (keep_inst || chance(p_inst)) begin
            inst_req  = 1'b1;
            inst_addr = $urandom;
        end
        if (data_req && s_dack) begin
            data_req = keep_data || chance(p_data);
            new_data_fields();
        end else if (data_req) begin
            if (chance(p_drop)) data_req = 1'b0;
        end else if (keep_data || chance(p_data)) begin
            data_req = 1'b1;
            new_data_fields();
        end
        if (s_macc) begin
            sl_busy = 1'b1;
            sl_lat  = int'($urandom_range(0, max_lat));
        end
        m_data_ok = 1'b0;
        if (sl_busy) begin
            if (sl_lat == 0) begin
                m_data_ok = 1'b1;
                m_rdata   = $urandom;
                sl_busy   = 1'b0;
            end else begin
                sl_lat--;
            end
        end else if (chance(p_spur)) begin
            m_data_ok = 1'b1;
            m_rdata   = $urandom;
        end
        m_addr_ok = chance(p_aok);
    endtask

    task automatic cycle_env();
        sample();
        s_iack = inst_addr_ok;
        s_dack = data_addr_ok;
        s_macc = m_req && m_addr_ok;
        tick();
        env_tick();
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0;
        data_req = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        sl_busy = 1'b0;
        keep_inst = 1'b0;
        keep_data = 1'b0;
    endtask

    // Requests and slave strobes are held active during reset: nothing may leak out.
    task automatic do_reset();
        tick();
        resetn = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        sample();
        check("reset m_req", 32'(m_req), 32'd0);
        check("reset oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        tick();
        clear_inputs();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_inst_only();
        do_reset();
        tick(); inst_req = 1'b1; inst_addr = 32'hBFC00000;
        sample(); check("t1 idle m_req", 32'(m_req), 32'd0);
        tick(); m_addr_ok = 1'b1;
        sample();
        check("t1 m_req", 32'(m_req), 32'd1);
        check("t1 m_addr", m_addr, 32'hBFC00000);
        check("t1 m_size", 32'(m_size), 32'd2);
        check("t1 inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; m_addr_ok = 1'b0;
        sample(); check("t1 resp m_req", 32'(m_req), 32'd0);
        tick(); m_data_ok = 1'b1; m_rdata = 32'h3C080001;
        sample();
        check("t1 inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("t1 inst_rdata", inst_rdata, 32'h3C080001);
        check("t1 data_data_ok", 32'(data_data_ok), 32'd0);
        tick(); m_data_ok = 1'b0;
        sample(); check("t1 pulse end", 32'(inst_data_ok), 32'd0);
    endtask

    task automatic test_tie();
        do_reset();
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'd0;
        data_addr = 32'h80001000;
        tick(); m_addr_ok = 1'b1;
        sample();
        check("t2 data first", m_addr, 32'h80001000);
        check("t2 data_addr_ok", 32'(data_addr_ok), 32'd1);
        check("t2 inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        tick(); data_req = 1'b0; m_addr_ok = 1'b0;
        tick(); m_data_ok = 1'b1; m_rdata = 32'h11223344;
        sample();
        check("t2 data_data_ok", 32'(data_data_ok), 32'd1);
        check("t2 data_rdata", data_rdata, 32'h11223344);
        check("t2 inst_data_ok", 32'(inst_data_ok), 32'd0);
        tick(); m_data_ok = 1'b0;
        sample();
        check("t2 no bubble m_req", 32'(m_req), 32'd1);
        check("t2 no bubble m_addr", m_addr, 32'hBFC00000);
        tick(); m_addr_ok = 1'b1;
        sample(); check("t2 inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        sample(); check("t2 inst_data_ok", 32'(inst_data_ok), 32'd1);
        tick(); m_data_ok = 1'b0;
    endtask

    task automatic test_store_stall();
        do_reset();
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
        data_addr = 32'h80000002; data_wdata = 32'h00AB0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            check("t4 stall m_req", 32'(m_req), 32'd1);
            check("t4 stall ctl", 32'({m_wr, m_size, m_wstrb}), 32'({1'b1, 2'd0, 4'b0100}));
            check("t4 stall addr", m_addr, 32'h80000002);
            check("t4 stall wdata", m_wdata, 32'h00AB0000);
            check("t4 stall no ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        end
        tick(); m_addr_ok = 1'b1;
        sample(); check("t4 data_addr_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        sample(); check("t4 store done", 32'(data_data_ok), 32'd1);
        tick(); m_data_ok = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001000;
        tick(); m_addr_ok = 1'b1;
        sample(); check("t5 accepted", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; m_addr_ok = 1'b0;
        tick(); resetn = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
        sample(); check("t5 in reset data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick(); resetn = 1'b1;
        sample();
        check("t5 late data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        check("t5 idle m_req", 32'(m_req), 32'd0);
        tick(); m_data_ok = 1'b0;
    endtask

    task automatic test_starve();
        int exp_seq [10];
`ifdef SRAM_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
        do_reset();
        keep_inst = 1'b1; keep_data = 1'b1;
        p_aok = 100; max_lat = 0; p_spur = 0; p_drop = 0;
        grant_log.delete();
        log_en = 1'b1;
        for (int c = 0; c < 300 && grant_log.size() < 10; c++) cycle_env();
        log_en = 1'b0;
        check("t3 grant count", 32'(grant_log.size() >= 10), 32'd1);
        if (grant_log.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("t3 grant %0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 15; seg++) begin
            if (seg % 5 == 0) do_reset();
            p_inst = int'($urandom_range(20, 90));
            p_data = int'($urandom_range(20, 90));
            keep_inst = chance(25);
            keep_data = chance(25);
            p_aok = int'($urandom_range(20, 100));
            max_lat = int'($urandom_range(0, 3));
            p_spur = int'($urandom_range(0, 30));
            p_drop = int'($urandom_range(0, 5));
            for (int c = 0; c < 200; c++) cycle_env();
        end
        clear_inputs();
    endtask

    initial begin
        test_inst_only();
        test_tie();
        test_store_stall();
        test_reset_in_resp();
        test_starve();
        test_random();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
